// File: rtl/stream_pkg.sv
// Shared definitions for the stream source generators: traffic modes, FSM
// states and the 16-bit gap LFSR polynomial.
package stream_pkg;

  typedef enum logic [1:0] {
    MODE_CONT  = 2'd0,
    MODE_GAP   = 2'd1,
    MODE_BURST = 2'd2,
    MODE_RAND  = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Taps 16,14,13,11 of a right-shifting Fibonacci LFSR land on bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_next(input logic [15:0] q);
    return {^(q & LFSR_TAPS), q[15:1]};
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous load (priority) and step enable.
module lfsr16
  import stream_pkg::*;
#(
  parameter logic [15:0] RST_VAL = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        advance,
  output logic [15:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RST_VAL;
    end else if (load) begin
      q <= seed;
    end else if (advance) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/stream_src_gen.sv
// Valid/ready stream source producing an incrementing pattern with
// continuous, gapped, counted-burst and pseudo-random-gap traffic modes.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | not generating; waits for start
// ST_SEND | valid=1, beat presented and held until the handshake
// ST_GAP  | valid=0 between beats (GAP: one cycle, RAND: until LFSR[0]=1)
module stream_src_gen
  import stream_pkg::*;
#(
  parameter int              DATA_W    = 32,
  parameter int              LEN_W     = 8,
  parameter logic [DATA_W-1:0] START_VAL = {{(DATA_W-1){1'b0}}, 1'b1},
  parameter logic [15:0]     LFSR_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [1:0]        mode,
  input  logic [LEN_W-1:0]  burst_len,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              last,
  input  logic              ready,
  output logic              busy,
  output logic [LEN_W-1:0]  beat_cnt
);

  state_t             state;
  mode_t              mode_q;
  mode_t              mode_in;
  logic [LEN_W-1:0]   len_q;
  logic [DATA_W-1:0]  cnt;
  logic [DATA_W-1:0]  cnt_nxt;
  logic [LEN_W-1:0]   beat_nxt;
  logic [15:0]        lfsr_q;
  logic [15:0]        lfsr_peek;
  logic               hs;
  logic               lfsr_load;
  logic               lfsr_adv;

  assign mode_in   = mode_t'(mode);
  assign hs        = valid & ready;
  assign cnt_nxt   = cnt + 1'b1;
  assign beat_nxt  = beat_cnt + 1'b1;
  assign lfsr_peek = lfsr_next(lfsr_q);
  assign lfsr_load = (state == ST_IDLE) & start;
  // The LFSR value seen in a gap cycle is always a fresh one, so a beat's
  // own LFSR bit never re-triggers the cycle right after its handshake.
  assign lfsr_adv  = (mode_q == MODE_RAND) &
                     ((state == ST_GAP) | ((state == ST_SEND) & hs));

  lfsr16 #(.RST_VAL(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (lfsr_load),
    .seed    (LFSR_SEED),
    .advance (lfsr_adv),
    .q       (lfsr_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      mode_q   <= MODE_CONT;
      len_q    <= '0;
      cnt      <= START_VAL;
      data     <= '0;
      valid    <= 1'b0;
      last     <= 1'b0;
      busy     <= 1'b0;
      beat_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            mode_q   <= mode_in;
            len_q    <= burst_len;
            cnt      <= START_VAL;
            data     <= START_VAL;
            beat_cnt <= '0;
            busy     <= 1'b1;
            last     <= (mode_in == MODE_BURST) && (burst_len == '0);
            if ((mode_in == MODE_RAND) && !LFSR_SEED[0]) begin
              state <= ST_GAP;
              valid <= 1'b0;
            end else begin
              state <= ST_SEND;
              valid <= 1'b1;
            end
          end
        end
        ST_SEND: begin
          if (hs) begin
            cnt      <= cnt_nxt;
            data     <= cnt_nxt;
            beat_cnt <= beat_nxt;
            if (mode_q == MODE_BURST) begin
              if (last) begin
                state <= ST_IDLE;
                valid <= 1'b0;
                last  <= 1'b0;
                busy  <= 1'b0;
              end else begin
                last <= (beat_nxt == len_q);
              end
            end else if (stop) begin
              state <= ST_IDLE;
              valid <= 1'b0;
              busy  <= 1'b0;
            end else if (mode_q != MODE_CONT) begin
              state <= ST_GAP;
              valid <= 1'b0;
            end
          end
        end
        ST_GAP: begin
          if (stop) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if ((mode_q == MODE_GAP) || lfsr_peek[0]) begin
            state <= ST_SEND;
            valid <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          valid <= 1'b0;
          last  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stream_src_gen.sv
// Bench for stream_src_gen: rule-based cycle model checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_stream_src_gen;

  localparam logic [31:0] START = 32'd1;
  localparam logic [15:0] SEED  = 16'hACE1;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic [1:0]  mode;
  logic [7:0]  burst_len;
  logic [31:0] data;
  logic        valid;
  logic        last;
  logic        ready;
  logic        busy;
  logic [7:0]  beat_cnt;

  int n_pass  = 0;
  int n_total = 0;

  stream_src_gen dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .burst_len (burst_len),
    .data      (data),
    .valid     (valid),
    .last      (last),
    .ready     (ready),
    .busy      (busy),
    .beat_cnt  (beat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LFSR step: taps 16,14,13,11, new bit enters at the top.
  function automatic logic [15:0] ref_step(input logic [15:0] s);
    logic b;
    b = s[0] ^ s[2] ^ s[3] ^ s[5];
    return (s >> 1) | (16'(b) << 15);
  endfunction

  // Model state: what the outputs must look like during the current cycle.
  logic        m_busy, m_valid, m_last, m_hs, m_done;
  logic [7:0]  m_beats, m_len;
  logic [31:0] m_data, m_next;
  logic [15:0] m_lfsr;
  logic [1:0]  m_mode;

  always begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_busy = 0; m_valid = 0; m_last = 0; m_beats = 0; m_len = 0;
      m_data = 0; m_next = START; m_lfsr = SEED; m_mode = 0;
    end else begin
      m_hs = m_valid && ready;
      if (!m_busy) begin
        m_valid = 0;
        m_last  = 0;
        if (start) begin
          m_busy  = 1; m_mode = mode; m_len = burst_len;
          m_next  = START; m_data = START; m_beats = 0; m_lfsr = SEED;
          m_valid = (mode != 2'd3) || SEED[0];
          m_last  = (mode == 2'd2) && (burst_len == 0);
        end
      end else if (!(m_valid && !ready)) begin
        // Either a handshake or a gap cycle; a stalled beat changes nothing.
        m_done = (m_mode == 2'd2) ? (m_hs && m_beats == m_len) : stop;
        if (m_hs) begin
          m_beats = m_beats + 8'd1;
          m_next  = m_next + 32'd1;
          m_data  = m_next;
        end
        if (m_done) begin
          m_busy = 0; m_valid = 0; m_last = 0;
        end else begin
          m_lfsr = ref_step(m_lfsr);
          case (m_mode)
            2'd1:    m_valid = !m_hs;
            2'd3:    m_valid = !m_hs && m_lfsr[0];
            default: m_valid = 1;
          endcase
          m_last = (m_mode == 2'd2) && (m_beats == m_len);
        end
      end
    end
  end

  always begin
    @(negedge clk);
    if (rst_n) begin
      n_total++;
      if (valid === m_valid && busy === m_busy && last === m_last &&
          beat_cnt === m_beats && (!m_valid || data === m_data))
        n_pass++;
      else
        $display("FAIL model t=%0t got/want: valid %b/%b busy %b/%b last %b/%b beat_cnt %0d/%0d data %0d/%0d",
                 $time, valid, m_valid, busy, m_busy, last, m_last, beat_cnt, m_beats, data, m_data);
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0d want %0d", name, got, want);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic kick(input logic [1:0] m, input logic [7:0] len);
    mode = m; burst_len = len; start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  // Expected RAND valid pattern for cycles 1..18 after start with ready=1.
  logic rand_pat [18] = '{1,0,0,0,0,1,0,1,0,0,1,0,0,1,0,1,0,1};

  task automatic rand_run(input string tag);
    for (int c = 1; c <= 18; c++) begin
      if (c > 1) cyc();
      check($sformatf("%s valid c%0d", tag, c), 64'(valid), 64'(rand_pat[c-1]));
      if (c == 1)  check({tag, " data c1"}, 64'(data), 64'd1);
      if (c == 18) check({tag, " data c18"}, 64'(data), 64'd7);
    end
  endtask

  initial begin
    rst_n = 0; start = 0; stop = 0; mode = 0; burst_len = 0; ready = 0;
    #3;
    check("reset data", 64'(data), 64'd0);
    check("reset valid", 64'(valid), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset last", 64'(last), 64'd0);
    check("reset beat_cnt", 64'(beat_cnt), 64'd0);
    @(posedge clk); #1; rst_n = 1;
    cyc();

    // CONT back-to-back, stop on the handshake of data=5
    ready = 1;
    kick(2'd0, 8'd0);
    check("cont c1 valid", 64'(valid), 64'd1);
    check("cont c1 data", 64'(data), 64'd1);
    for (int c = 2; c <= 5; c++) cyc();
    check("cont c5 data", 64'(data), 64'd5);
    stop = 1; cyc(); stop = 0;
    check("cont stop valid", 64'(valid), 64'd0);
    check("cont stop busy", 64'(busy), 64'd0);
    cyc();

    // CONT with ready 1,0,0,1
    ready = 1;
    kick(2'd0, 8'd0);
    cyc(); ready = 0;
    cyc();
    check("stall c3 valid", 64'(valid), 64'd1);
    check("stall c3 data", 64'(data), 64'd2);
    cyc(); ready = 1;
    cyc();
    check("stall c5 data", 64'(data), 64'd3);
    stop = 1; cyc(); stop = 0;
    check("stall stop busy", 64'(busy), 64'd0);
    cyc();

    // GAP, stop issued during a gap cycle
    ready = 1;
    kick(2'd1, 8'd0);
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) cyc();
      check($sformatf("gap valid c%0d", c), 64'(valid), 64'(c % 2));
    end
    stop = 1; cyc(); stop = 0;
    check("gap stop busy", 64'(busy), 64'd0);
    cyc();

    // BURST len 3 with stop held and a start mid-burst, both ignored
    ready = 1; stop = 1;
    kick(2'd2, 8'd3);
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) cyc();
      check($sformatf("burst data c%0d", c), 64'(data), 64'(c));
      check($sformatf("burst last c%0d", c), 64'(last), 64'(c == 4));
      if (c == 2) begin mode = 2'd0; start = 1; end
      if (c == 3) start = 0;
    end
    cyc();
    check("burst done busy", 64'(busy), 64'd0);
    check("burst done beat_cnt", 64'(beat_cnt), 64'd4);
    stop = 0;
    cyc();

    // BURST len 0 with ready low for three cycles
    ready = 0;
    kick(2'd2, 8'd0);
    cyc(); cyc();
    check("single c3 valid", 64'(valid), 64'd1);
    check("single c3 data", 64'(data), 64'd1);
    check("single c3 last", 64'(last), 64'd1);
    ready = 1; cyc();
    check("single done busy", 64'(busy), 64'd0);
    check("single done beat_cnt", 64'(beat_cnt), 64'd1);
    cyc();

    // BURST of 256 beats: beat_cnt wraps to 0 on the final handshake
    ready = 1;
    kick(2'd2, 8'd255);
    for (int c = 2; c <= 256; c++) cyc();
    check("long c256 data", 64'(data), 64'd256);
    check("long c256 last", 64'(last), 64'd1);
    cyc();
    check("long done busy", 64'(busy), 64'd0);
    check("long done beat_cnt", 64'(beat_cnt), 64'd0);
    cyc();

    // RAND, async reset while data=7 is on the bus, then an identical rerun
    ready = 1;
    kick(2'd3, 8'd0);
    rand_run("rand1");
    #6 rst_n = 0;
    #1;
    check("async data", 64'(data), 64'd0);
    check("async valid", 64'(valid), 64'd0);
    check("async busy", 64'(busy), 64'd0);
    check("async beat_cnt", 64'(beat_cnt), 64'd0);
    @(posedge clk); #1; rst_n = 1;
    kick(2'd3, 8'd0);
    rand_run("rand2");
    stop = 1; cyc(); stop = 0;
    check("rand stop busy", 64'(busy), 64'd0);
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got time %0t want < 100000", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/stream_src_gen.md
Name: stream_src_gen

Overview:
- Parametrised valid/ready stream source for exercising AXI-style handshake sinks.
- Generates an incrementing data pattern and obeys the handshake rules strictly:
  - valid never depends on ready;
  - data and last hold stable while valid is high and ready is low.
- Adds selectable traffic modes (continuous, gapped, counted burst with last, pseudo-random gaps) and start/stop control.
- Sits at the upstream end of handshake test benches and link blocks.

Parameters:
- DATA_W, 32, width of data and the pattern counter.
- LEN_W, 8, width of burst_len and beat_cnt.
- START_VAL, 1, first data value after start; counter reloads to this on every start.
- LFSR_SEED, 16'hACE1, reset and start value of the 16-bit gap LFSR; must be non-zero.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; begins generation; ignored unless busy=0.
- stop  in  1  level; requests end of continuous, gapped or random generation.
- mode  in  2  0=CONT, 1=GAP, 2=BURST, 3=RAND; sampled only on accepted start.
- burst_len  in  LEN_W  BURST beat count minus 1; sampled on accepted start.
- data  out  DATA_W  payload.
- valid  out  1  beat available.
- last  out  1  final beat of a BURST; 0 in all other modes.
- ready  in  1  sink accepts beat.
- busy  out  1  high from the accepted start until generation ends.
- beat_cnt  out  LEN_W  handshakes completed since start; wraps modulo 2^LEN_W.

Behaviour:
- Reset, asynchronous on rst_n low:
  - data=0, valid=0, last=0, busy=0, beat_cnt=0.
  - Pattern counter=START_VAL, LFSR=LFSR_SEED, state=IDLE.
- Handshake:
  - A beat transfers on the rising edge where valid&&ready=1.
  - While valid=1 and ready=0, data, last and valid hold unchanged. No retraction of valid is allowed.
  - The pattern counter increments (wrapping at 2^DATA_W) only on a handshake. Values are never skipped or duplicated.
- Registered outputs. No combinational path from ready to valid or data.
- FSM states: IDLE, SEND, GAP.
- IDLE:
  - valid=0, busy=0.
  - On start: latch mode and burst_len, load the counter with START_VAL, clear beat_cnt, load the LFSR with LFSR_SEED.
  - Next cycle: busy=1, valid=1, data=START_VAL, go to SEND.
  - Exception: in RAND mode, valid first rises on the first cycle with LFSR[0]=1; the FSM waits in GAP until then.
- SEND, on handshake:
  - CONT: if stop=1, go to IDLE with valid=0. Otherwise stay in SEND; the next data is presented on the following cycle, valid stays 1, giving back-to-back beats.
  - GAP: go to GAP; valid=0 for exactly one cycle, then return to SEND. If stop=1 at the handshake, go to IDLE instead.
  - BURST:
    - last=1 is presented on the beat where beat_cnt==burst_len.
    - The handshake on that beat goes to IDLE: valid=0, last=0, busy=0.
    - stop is ignored in BURST; a burst always completes.
  - RAND: go to GAP. stop=1 at the handshake goes to IDLE.
- GAP, RAND mode:
  - The LFSR advances every cycle in GAP.
  - Return to SEND and raise valid on the first cycle with LFSR[0]=1.
  - stop=1 while in GAP goes to IDLE.
- GAP, GAP mode: stop=1 while in GAP goes to IDLE.
- stop while valid=1 and the beat is not yet accepted: ignored until the handshake, so the beat is never dropped.
- burst_len=0 gives a single beat with last=1.
- burst_len=2^LEN_W-1 gives 2^LEN_W beats; beat_cnt wraps to 0 on the final handshake.
- start while busy=1: ignored, with no effect on state or outputs.
- Reset mid-beat: all outputs drop immediately (asynchronously) to reset values. Next start begins at START_VAL.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11.

Decomposition:
- Shared package stream_pkg:
  - mode encodings MODE_CONT/MODE_GAP/MODE_BURST/MODE_RAND;
  - FSM state typedef;
  - LFSR tap constant.
- One natural sub-module: lfsr16, with clk, rst_n, load, seed, advance, q. It is reusable by other traffic generators in the bench.

Test Plan:
- CONT, ready tied 1, start at cycle 0: valid rises at cycle 1; data 1,2,3,4... on consecutive cycles. Assert stop at the handshake of data=5: valid=0 the next cycle, busy=0.
- CONT, ready pattern 1,0,0,1: data=2 is held with valid=1 for the two stalled cycles; the next beat is data=3. No value skipped or duplicated.
- GAP, ready=1: valid toggles 1,0,1,0; data sequence 1,2,3 on the valid cycles.
- BURST, burst_len=3, ready=1: 4 beats, data 1..4, last=1 only with data=4. busy drops the cycle after; beat_cnt=4. A start issued mid-burst is ignored.
- BURST, burst_len=0, ready low for 3 cycles: a single beat data=1, last=1, held stable until ready=1, then IDLE.
- RAND with LFSR_SEED default and reset: deassert rst_n mid-beat while valid=1, data=7; outputs go to 0 asynchronously. After restart, data begins at 1 again and the valid gap pattern repeats identically, because the seed is reloaded.
